game_round_ctrl: RTL

//  Round controller directly upstream of the countdown timer: holds the timer in reset

---
 rtl/game_pkg.sv | 16 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/game_round_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller: FSM state encoding and
// 4-digit BCD score limits.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        PLAY = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam int          BCD_DIGITS  = 4;
    localparam logic [15:0] BCD_MAX     = 16'h9999;

endpackage

// File: rtl/btn_debounce.sv
// Level debouncer: the output follows the input only after the input has differed from
// the current output for DEBOUNCE_CYCLES consecutive clocks.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (din == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = din;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: gates the countdown timer, keeps round/best score in BCD.
// Define MISS_PENALTY_EN to make miss_evt decrement the score and pulse penalty.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOW_TIME_THRESH = 100000,
    parameter int TIMER_W         = 21
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               hit_evt,
    input  logic               miss_evt,
    input  logic               game_over,
    input  logic [TIMER_W-1:0] timer_value,
    output logic               timer_rst,
    output logic [1:0]         state,
    output logic [15:0]        score_bcd,
    output logic [15:0]        best_bcd,
    output logic               low_time,
    output logic               penalty
);

    // Saturating BCD increment, per-digit carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = (v != BCD_MAX);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (r[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                    r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                end else begin
                    r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = r[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Saturating BCD decrement, per-digit borrow; stays at zero.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = (v != 16'h0000);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (borrow) begin
                if (r[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0) begin
                    r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
                end else begin
                    r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = r[i*BCD_DIGIT_W +: BCD_DIGIT_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise compare, most significant digit decides.
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            if (!done && (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] != b[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                gt   = a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > b[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                done = 1'b1;
            end
        end
        return gt;
    endfunction

    logic        sync1_q, sync2_q;
    logic        btn_level, btn_prev_q;
    logic        start_edge;
    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [15:0] best_q, best_d;
    logic        low_time_q, low_time_d;
    logic        penalty_q, penalty_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .din  (sync2_q),
        .level(btn_level)
    );

    assign start_edge = btn_level & ~btn_prev_q;

`ifndef MISS_PENALTY_EN
    logic unused_miss;
    assign unused_miss = miss_evt;
`endif

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        best_d     = best_q;
        penalty_d  = 1'b0;
        low_time_d = (state_q == PLAY) && (timer_value < TIMER_W'(LOW_TIME_THRESH));
        case (state_q)
            IDLE: if (start_edge) state_d = ARM;
            ARM: begin
                score_d = '0;
                state_d = PLAY;
            end
            PLAY: begin
                // A hit coinciding with game_over is dropped; best captures the final score.
                if (game_over) begin
                    state_d = OVER;
                    if (bcd_gt(score_q, best_q)) best_d = score_q;
                end else begin
`ifdef MISS_PENALTY_EN
                    if (miss_evt) begin
                        penalty_d = 1'b1;
                        if (!hit_evt) score_d = bcd_dec(score_q);
                    end else if (hit_evt) begin
                        score_d = bcd_inc(score_q);
                    end
`else
                    if (hit_evt) score_d = bcd_inc(score_q);
`endif
                end
            end
            OVER: if (start_edge) state_d = ARM;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_prev_q <= 1'b0;
            state_q    <= IDLE;
            score_q    <= '0;
            best_q     <= '0;
            low_time_q <= 1'b0;
            penalty_q  <= 1'b0;
        end else begin
            sync1_q    <= btn_start;
            sync2_q    <= sync1_q;
            btn_prev_q <= btn_level;
            state_q    <= state_d;
            score_q    <= score_d;
            best_q     <= best_d;
            low_time_q <= low_time_d;
            penalty_q  <= penalty_d;
        end
    end

    assign timer_rst = (state_q == IDLE) || (state_q == ARM);
    assign state     = state_q;
    assign score_bcd = score_q;
    assign best_bcd  = best_q;
    assign low_time  = low_time_q;
    assign penalty   = penalty_q;

endmodule
